// File: rtl/seq_mem_arbiter_2.sv
// Round-robin arbiter that shares one single-port sequential memory between two requesters.
// One access is outstanding at a time; out-of-range addresses are answered locally with resp_err.
module seq_mem_arbiter_2 #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 144,
  parameter int IDX_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*IDX_SIZE-1:0] req_addr0,
  input  logic [2*WIDTH-1:0]    req_in,
  output logic [1:0]            req_ready,
  output logic [1:0]            resp_valid,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      resp_out,
  output logic [IDX_SIZE-1:0]   mem_addr0,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [WIDTH-1:0]      mem_in,
  input  logic [WIDTH-1:0]      mem_out,
  input  logic                  mem_read_done,
  input  logic                  mem_write_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  rr_ptr_r;
  logic                  in_reset_r;
  logic                  op_we_r;
  logic                  op_gnt_r;
  logic [IDX_SIZE-1:0]   op_addr_r;
  logic [WIDTH-1:0]      op_data_r;
  logic                  gnt_s;
  logic                  hs_s;
  logic                  sel_we_s;
  logic                  in_range_s;
  logic                  done_s;
  logic [IDX_SIZE-1:0]   sel_addr_s;
  logic [WIDTH-1:0]      sel_data_s;

  // Grant selection and handshake; no grant in reset or in the cycle right after it
  always_comb begin
    gnt_s = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_s = rr_ptr_r;
    end else if (req_valid[1]) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    hs_s       = (state_r == IDLE) && !reset && !in_reset_r && (req_valid != 2'b00);
    sel_we_s   = gnt_s ? req_we[1] : req_we[0];
    sel_addr_s = gnt_s ? req_addr0[2*IDX_SIZE-1:IDX_SIZE] : req_addr0[IDX_SIZE-1:0];
    sel_data_s = gnt_s ? req_in[2*WIDTH-1:WIDTH] : req_in[WIDTH-1:0];
    in_range_s = ({1'b0, sel_addr_s} < (IDX_SIZE+1)'(SIZE));
    done_s     = op_we_r ? mem_write_done : mem_read_done;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Remembers that the previous cycle was in reset, holding off the first grant by one cycle
  always_ff @(posedge clk) begin
    in_reset_r <= reset;
  end

  // Operation registers and round-robin pointer, captured on the accepting handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r  <= 1'b0;
      op_we_r   <= 1'b0;
      op_gnt_r  <= 1'b0;
      op_addr_r <= {IDX_SIZE{1'b0}};
      op_data_r <= {WIDTH{1'b0}};
    end else if (hs_s) begin
      rr_ptr_r  <= ~gnt_s;
      op_we_r   <= sel_we_s;
      op_gnt_r  <= gnt_s;
      op_addr_r <= sel_addr_s;
      op_data_r <= sel_data_s;
    end else begin
      rr_ptr_r  <= rr_ptr_r;
      op_we_r   <= op_we_r;
      op_gnt_r  <= op_gnt_r;
      op_addr_r <= op_addr_r;
      op_data_r <= op_data_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_next_s = in_range_s ? ISSUE : ERR;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE:   state_next_s = WAIT;
      WAIT: begin
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Outputs; everything handshake-related is forced low while reset is asserted
  always_comb begin
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    resp_err     = 1'b0;
    resp_out     = {WIDTH{1'b0}};
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr0    = op_addr_r;
    mem_in       = op_data_r;
    if (!reset) begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            req_ready[gnt_s] = 1'b1;
          end else begin
            req_ready = 2'b00;
          end
        end
        ISSUE: begin
          mem_read_en  = !op_we_r;
          mem_write_en = op_we_r;
        end
        WAIT: begin
          if (done_s) begin
            resp_valid[op_gnt_r] = 1'b1;
            resp_out             = op_we_r ? {WIDTH{1'b0}} : mem_out;
          end else begin
            resp_valid = 2'b00;
          end
        end
        ERR: begin
          resp_valid[op_gnt_r] = 1'b1;
          resp_err             = 1'b1;
        end
        default: resp_valid = 2'b00;
      endcase
    end else begin
      req_ready = 2'b00;
    end
  end

endmodule

// File: tb/tb_seq_mem_arbiter_2.sv
// Directed bench for seq_mem_arbiter_2: a memory stub, a cycle-timeline model of the arbiter's
// promised behaviour checked every cycle, and literal expectations on each transaction.
module tb_seq_mem_arbiter_2;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_we, req_ready, resp_valid;
  logic [15:0] req_addr0;
  logic [63:0] req_in;
  logic        resp_err, mem_read_en, mem_write_en, mem_read_done, mem_write_done;
  logic [31:0] resp_out, mem_in, mem_out;
  logic [7:0]  mem_addr0;

  int errors = 0;
  int checks = 0;

  seq_mem_arbiter_2 dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_in(req_in), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_out(resp_out),
    .mem_addr0(mem_addr0), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_in(mem_in), .mem_out(mem_out), .mem_read_done(mem_read_done),
    .mem_write_done(mem_write_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: one-cycle registered access with done pulses
  logic [31:0] store [144];
  always @(posedge clk) begin
    mem_read_done  <= 1'b0;
    mem_write_done <= 1'b0;
    if (mem_read_en) begin
      mem_out       <= (mem_addr0 < 8'd144) ? store[mem_addr0] : 32'hBAD0BAD0;
      mem_read_done <= 1'b1;
    end
    if (mem_write_en) begin
      if (mem_addr0 < 8'd144) store[mem_addr0] <= mem_in;
      mem_write_done <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Timeline model: each accept schedules an enable one cycle later and a response one
  // (error) or two (memory) cycles later; the next accept is allowed once the response is out.
  logic [1:0]  s_en   [8];
  logic [7:0]  s_addr [8];
  logic [31:0] s_data [8];
  logic [1:0]  s_rv   [8];
  logic        s_err  [8];
  logic [31:0] s_out  [8];
  logic [31:0] shadow [144];
  int          cyc = 0;
  int          free_at = 0;
  logic        rr = 1'b0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      s_en[i] = 2'b00; s_rv[i] = 2'b00; s_err[i] = 1'b0;
      s_addr[i] = 8'h00; s_data[i] = 32'h0; s_out[i] = 32'h0;
    end
    forever begin
      int          sl, g, a, n1, n2;
      logic [1:0]  e_ready, e_en, e_rv;
      logic        we;
      logic [31:0] d;
      @(negedge clk);
      cyc++;
      sl = cyc % 8;
      e_ready = 2'b00;
      if (reset) begin
        for (int i = 0; i < 8; i++) begin s_en[i] = 2'b00; s_rv[i] = 2'b00; end
        rr = 1'b0;
        free_at = cyc + 2;
      end else if (cyc >= free_at && req_valid != 2'b00) begin
        g  = (req_valid == 2'b11) ? int'(rr) : (req_valid[1] ? 1 : 0);
        e_ready[g] = 1'b1;
        rr = (g == 0);
        we = req_we[g];
        a  = int'(req_addr0[g*8 +: 8]);
        d  = req_in[g*32 +: 32];
        n1 = (cyc + 1) % 8;
        n2 = (cyc + 2) % 8;
        if (a < 144) begin
          s_en[n1] = we ? 2'b10 : 2'b01;
          s_addr[n1] = a[7:0];
          s_data[n1] = d;
          s_rv[n2] = (g == 1) ? 2'b10 : 2'b01;
          s_err[n2] = 1'b0;
          s_out[n2] = we ? 32'h0 : shadow[a];
          if (we) shadow[a] = d;
          free_at = cyc + 3;
        end else begin
          s_rv[n1] = (g == 1) ? 2'b10 : 2'b01;
          s_err[n1] = 1'b1;
          s_out[n1] = 32'h0;
          free_at = cyc + 2;
        end
      end
      e_en = reset ? 2'b00 : s_en[sl];
      e_rv = reset ? 2'b00 : s_rv[sl];
      check("req_ready", req_ready, e_ready);
      check("mem_en", {mem_write_en, mem_read_en}, e_en);
      check("rd_wr_excl", mem_read_en & mem_write_en, 1'b0);
      check("resp_valid", resp_valid, e_rv);
      if (e_en != 2'b00) check("mem_addr0", mem_addr0, s_addr[sl]);
      if (e_en == 2'b10) check("mem_in", mem_in, s_data[sl]);
      if (e_rv != 2'b00) begin
        check("resp_err", resp_err, s_err[sl]);
        check("resp_out", resp_out, s_out[sl]);
      end
      s_en[sl] = 2'b00;
      s_rv[sl] = 2'b00;
    end
  end

  // Drive one request until accepted, then wait for its response (both bounded)
  task automatic do_req(input int r, input logic we, input logic [7:0] a, input logic [31:0] d,
                        output int wait_n, output int lat, output logic [31:0] rdata,
                        output logic err, output time acc_t);
    req_we[r] = we; req_addr0[r*8 +: 8] = a; req_in[r*32 +: 32] = d; req_valid[r] = 1'b1;
    wait_n = 0; lat = 0; rdata = 32'h0; err = 1'b0; acc_t = 0;
    do begin @(negedge clk); wait_n++; end while (!req_ready[r] && wait_n < 40);
    if (!req_ready[r]) begin
      check("accept_timeout", {63'd0, req_ready[r]}, 64'd1);
      req_valid[r] = 1'b0;
      return;
    end
    acc_t = $time;
    @(posedge clk); #1 req_valid[r] = 1'b0;
    do begin @(negedge clk); lat++; end while (!resp_valid[r] && lat < 10);
    if (!resp_valid[r]) check("resp_timeout", {63'd0, resp_valid[r]}, 64'd1);
    rdata = resp_out; err = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic rq(input int r, input logic we, input logic [7:0] a, input logic [31:0] d,
                    input logic [31:0] exp_d, input logic exp_err, input int exp_lat,
                    input string tag, output int wait_n, output time acc_t);
    int lat;
    logic [31:0] rd;
    logic e;
    do_req(r, we, a, d, wait_n, lat, rd, e, acc_t);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, e, exp_err);
    if (!we && !exp_err) check({tag, "_data"}, rd, exp_d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int  w0, w1, w2, w3, n;
    time t0, t1, t2, t3;
    reset = 1'b1; req_valid = 2'b00; req_we = 2'b00; req_addr0 = 16'h0; req_in = 64'h0;
    for (int i = 0; i < 144; i++) begin store[i] = 32'h0; shadow[i] = 32'h0; end

    // Contention at reset exit: req0 wins, req1 follows three cycles later
    fork
      rq(0, 1'b1, 8'd1, 32'h11, 32'h0, 1'b0, 2, "tie_w0", w0, t0);
      rq(1, 1'b1, 8'd2, 32'h22, 32'h0, 1'b0, 2, "tie_w1", w1, t1);
      begin repeat (2) @(posedge clk); #1 reset = 1'b0; end
    join
    check("tie_wait0", w0, 3);
    check("tie_wait1", w1, 6);

    // Continuous requests alternate 0,1,0,1
    fork
      begin
        rq(0, 1'b0, 8'd1, 32'h0, 32'h11, 1'b0, 2, "alt0a", w0, t0);
        rq(0, 1'b0, 8'd1, 32'h0, 32'h11, 1'b0, 2, "alt0b", w2, t2);
      end
      begin
        rq(1, 1'b0, 8'd2, 32'h0, 32'h22, 1'b0, 2, "alt1a", w1, t1);
        rq(1, 1'b0, 8'd2, 32'h0, 32'h22, 1'b0, 2, "alt1b", w3, t3);
      end
    join
    check("alt_order", {61'd0, t0 < t1, t1 < t2, t2 < t3}, 64'd7);

    // Single write then read, and the in-range / out-of-range boundaries
    rq(0, 1'b1, 8'd5,   32'hDEADBEEF, 32'h0,        1'b0, 2, "wr5",   w0, t0);
    rq(0, 1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 1'b0, 2, "rd5",   w0, t0);
    rq(1, 1'b1, 8'd143, 32'hCAFEF00D, 32'h0,        1'b0, 2, "wr143", w0, t0);
    rq(1, 1'b0, 8'd143, 32'h0,        32'hCAFEF00D, 1'b0, 2, "rd143", w0, t0);
    rq(0, 1'b0, 8'd144, 32'h0,        32'h0,        1'b1, 1, "rd144", w0, t0);
    rq(1, 1'b1, 8'd255, 32'h55,       32'h0,        1'b1, 1, "wr255", w0, t0);

    // Back-to-back reads from one requester: one accept every three cycles
    for (int i = 0; i < 10; i++) begin
      rq(0, 1'b0, (i % 2 == 0) ? 8'd5 : 8'd143, 32'h0,
         (i % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0, 2, "b2b", w0, t0);
      if (i > 0) check("b2b_wait", w0, 1);
    end

    // Held request: payload changes while blocked; the handshake-cycle payload is used
    fork
      rq(0, 1'b1, 8'd20, 32'h12345678, 32'h0, 1'b0, 2, "hold_w0", w0, t0);
      begin
        @(negedge clk);
        @(posedge clk); #1 req_we[1] = 1'b1; req_addr0[15:8] = 8'd10; req_in[63:32] = 32'hAAAAAAAA;
        req_valid[1] = 1'b1;
        @(posedge clk); #1 req_addr0[15:8] = 8'd11; req_in[63:32] = 32'hBBBBBBBB;
        rq(1, 1'b1, 8'd11, 32'hBBBBBBBB, 32'h0, 1'b0, 2, "hold_w1", w1, t1);
      end
    join
    check("hold_wait", w1, 2);
    rq(1, 1'b0, 8'd11, 32'h0, 32'hBBBBBBBB, 1'b0, 2, "hold_rd11", w0, t0);
    rq(1, 1'b0, 8'd10, 32'h0, 32'h0,        1'b0, 2, "hold_rd10", w0, t0);
    rq(1, 1'b0, 8'd20, 32'h0, 32'h12345678, 1'b0, 2, "hold_rd20", w0, t0);

    // Reset in the WAIT cycle of a req0 read: no response, then req0 wins a tie
    req_we[0] = 1'b0; req_addr0[7:0] = 8'd5; req_valid[0] = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 20);
    check("midop_accept", req_ready[0], 1'b1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    fork
      begin
        @(negedge clk);
        check("midop_no_resp", resp_valid, 2'b00);
        @(posedge clk); #1 reset = 1'b0;
      end
      rq(0, 1'b0, 8'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, "post_w0", w0, t0);
      rq(1, 1'b0, 8'd1, 32'h0, 32'h11,       1'b0, 2, "post_w1", w1, t1);
    join
    check("post_wait0", w0, 3);
    check("post_wait1", w1, 6);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
